// File: rtl/qeciphy_rx_monitor.sv
// qeciphy_rx_monitor
//
// Receive-side frame monitor. It sits between the aligned 64-bit RX datapath
// and the link controller. It finds the Frame Alignment Pattern (FAP) word
// that starts each frame and confirms it over several frames before it
// declares lock. It also watches for lost framing, decodes the remote
// link-status flags carried in the FAP, and forwards payload words downstream
// with one cycle of latency.
//
// Ports
//   axis_clk          in   1   clock
//   axis_rst          in   1   synchronous active-high reset
//   i_enable          in   1   monitor enable; low returns to HUNT and clears outputs
//   i_rx_tdata        in  64   received word
//   i_rx_tvalid       in   1   received word valid
//   o_tdata           out 64   payload word (holds while o_tvalid is low)
//   o_tvalid          out  1   payload valid
//   o_rx_rdy          out  1   frame lock achieved
//   o_fap_missing     out  1   sticky loss-of-frame
//   o_remote_rx_rdy   out  1   FAP bit 0 of last good FAP (0 unless locked)
//   o_remote_pd_req   out  1   FAP bit 1 of last good FAP (0 unless locked)
//   o_remote_pd_ack   out  1   FAP bit 2 of last good FAP (0 unless locked)
//   o_miss_count      out 16   saturating count of bad FAP slots while locked
//                              (present only when QECIPHY_RX_MON_STATS_EN is defined)
//
// Build option
//   QECIPHY_RX_MON_STATS_EN : define this macro to add o_miss_count and its counter.

module qeciphy_rx_monitor #(
  parameter int unsigned FRAME_LEN   = 16,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned MISS_LIMIT  = 2,
  parameter logic [47:0] FAP_PATTERN = 48'hA5C3_96F0_5A3C
) (
  input  logic        axis_clk,
  input  logic        axis_rst,
  input  logic        i_enable,
  input  logic [63:0] i_rx_tdata,
  input  logic        i_rx_tvalid,
  output logic [63:0] o_tdata,
  output logic        o_tvalid,
  output logic        o_rx_rdy,
  output logic        o_fap_missing,
  output logic        o_remote_rx_rdy,
  output logic        o_remote_pd_req,
  output logic        o_remote_pd_ack
`ifdef QECIPHY_RX_MON_STATS_EN
  ,
  output logic [15:0] o_miss_count
`endif
);

  localparam int unsigned POS_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [POS_W-1:0] pos, pos_next;
  logic [3:0]       verify_cnt, verify_next;
  logic [3:0]       miss_cnt, miss_next;

  logic fap_match;
  logic fap_slot;
  logic load_flags;
  logic slot_miss;

  // A FAP match only needs the fixed upper pattern. The low bits carry flags
  // and reserved fields.
  assign fap_match = i_rx_tvalid && (i_rx_tdata[63:16] == FAP_PATTERN);
  assign fap_slot  = i_rx_tvalid && (pos == '0);

  // State register and frame counters.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state      <= ST_HUNT;
      pos        <= '0;
      verify_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      state      <= state_next;
      pos        <= pos_next;
      verify_cnt <= verify_next;
      miss_cnt   <= miss_next;
    end
  end

  // Next-state logic. load_flags marks a good FAP slot that leaves us (or
  // keeps us) in LOCKED, so the flag registers capture that FAP's bits.
  always_comb begin
    state_next  = state;
    pos_next    = pos;
    verify_next = verify_cnt;
    miss_next   = miss_cnt;
    load_flags  = 1'b0;
    slot_miss   = 1'b0;

    if (!i_enable) begin
      state_next  = ST_HUNT;
      pos_next    = '0;
      verify_next = '0;
      miss_next   = '0;
    end else begin
      // Outside HUNT the position tracks every valid word and wraps at frame end.
      if ((state != ST_HUNT) && i_rx_tvalid) begin
        pos_next = (pos == POS_LAST) ? '0 : pos + POS_ONE;
      end

      case (state)
        ST_HUNT: begin
          if (fap_match) begin
            pos_next    = POS_ONE;
            verify_next = 4'd1;
            miss_next   = '0;
            if (LOCK_COUNT == 1) begin
              state_next = ST_LOCKED;
              load_flags = 1'b1;
            end else begin
              state_next = ST_VERIFY;
            end
          end
        end

        ST_VERIFY: begin
          if (fap_slot) begin
            if (fap_match) begin
              if (({28'd0, verify_cnt} + 32'd1) >= LOCK_COUNT) begin
                state_next  = ST_LOCKED;
                verify_next = '0;
                miss_next   = '0;
                load_flags  = 1'b1;
              end else begin
                verify_next = verify_cnt + 4'd1;
              end
            end else begin
              state_next  = ST_HUNT;
              pos_next    = '0;
              verify_next = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (fap_slot) begin
            if (fap_match) begin
              miss_next  = '0;
              load_flags = 1'b1;
            end else begin
              slot_miss = 1'b1;
              miss_next = miss_cnt + 4'd1;
              if (({28'd0, miss_cnt} + 32'd1) >= MISS_LIMIT) begin
                state_next = ST_LOST;
              end
            end
          end
        end

        ST_LOST: begin
          // Terminal until the monitor is disabled or reset.
        end

        default: begin
          state_next = ST_HUNT;
          pos_next   = '0;
        end
      endcase
    end
  end

  // Status outputs follow the state being entered, so they change in the
  // cycle after the transition. The remote flags are forced to zero whenever
  // we are not LOCKED.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      o_rx_rdy        <= 1'b0;
      o_fap_missing   <= 1'b0;
      o_remote_rx_rdy <= 1'b0;
      o_remote_pd_req <= 1'b0;
      o_remote_pd_ack <= 1'b0;
    end else begin
      o_rx_rdy      <= (state_next == ST_LOCKED);
      o_fap_missing <= (state_next == ST_LOST);
      if (state_next != ST_LOCKED) begin
        o_remote_rx_rdy <= 1'b0;
        o_remote_pd_req <= 1'b0;
        o_remote_pd_ack <= 1'b0;
      end else if (load_flags) begin
        o_remote_rx_rdy <= i_rx_tdata[0];
        o_remote_pd_req <= i_rx_tdata[1];
        o_remote_pd_ack <= i_rx_tdata[2];
      end
    end
  end

  // Payload path. Only words in non-FAP positions are forwarded while LOCKED.
  // A pattern match away from position 0 is still treated as payload.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      o_tdata  <= '0;
      o_tvalid <= 1'b0;
    end else if (!i_enable) begin
      o_tdata  <= '0;
      o_tvalid <= 1'b0;
    end else if ((state == ST_LOCKED) && i_rx_tvalid && (pos != '0)) begin
      o_tdata  <= i_rx_tdata;
      o_tvalid <= 1'b1;
    end else begin
      o_tvalid <= 1'b0;
    end
  end

`ifdef QECIPHY_RX_MON_STATS_EN
  // Lifetime count of bad FAP slots seen while locked. It survives relock
  // and is cleared only by reset or by disabling the monitor.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      o_miss_count <= '0;
    end else if (!i_enable) begin
      o_miss_count <= '0;
    end else if (slot_miss && (o_miss_count != 16'hFFFF)) begin
      o_miss_count <= o_miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qeciphy_rx_monitor.sv
// tb_qeciphy_rx_monitor
//
// Directed bench for qeciphy_rx_monitor with default parameters
// (FRAME_LEN=16, LOCK_COUNT=4, MISS_LIMIT=2). It covers lock acquisition,
// verify failure, single-miss recovery, loss of frame, remote flags with
// valid gaps, and mid-frame disable/reset followed by relock.
// Define QECIPHY_RX_MON_STATS_EN to also check o_miss_count.

module tb_qeciphy_rx_monitor;

  localparam logic [47:0] FAP_PAT = 48'hA5C3_96F0_5A3C;
  localparam logic [63:0] BAD_FAP = {48'hA5C3_96F0_5A3D, 16'h0001};

  logic        axis_clk;
  logic        axis_rst;
  logic        i_enable;
  logic [63:0] i_rx_tdata;
  logic        i_rx_tvalid;
  logic [63:0] o_tdata;
  logic        o_tvalid;
  logic        o_rx_rdy;
  logic        o_fap_missing;
  logic        o_remote_rx_rdy;
  logic        o_remote_pd_req;
  logic        o_remote_pd_ack;
`ifdef QECIPHY_RX_MON_STATS_EN
  logic [15:0] o_miss_count;
`endif

  int total  = 0;
  int bad    = 0;
  int vcount = 0;

  qeciphy_rx_monitor dut (
    .axis_clk        (axis_clk),
    .axis_rst        (axis_rst),
    .i_enable        (i_enable),
    .i_rx_tdata      (i_rx_tdata),
    .i_rx_tvalid     (i_rx_tvalid),
    .o_tdata         (o_tdata),
    .o_tvalid        (o_tvalid),
    .o_rx_rdy        (o_rx_rdy),
    .o_fap_missing   (o_fap_missing),
    .o_remote_rx_rdy (o_remote_rx_rdy),
    .o_remote_pd_req (o_remote_pd_req),
    .o_remote_pd_ack (o_remote_pd_ack)
`ifdef QECIPHY_RX_MON_STATS_EN
    ,
    .o_miss_count    (o_miss_count)
`endif
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  // The reserved bits [15:3] are non-zero so the match has to ignore them.
  function automatic logic [63:0] fapWord(input logic [2:0] flags);
    return {FAP_PAT, 13'h1ABC, flags};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one word for one clock. Outputs are sampled 1 time unit after the
  // edge, so they show the effect of the word just presented.
  task automatic applyStimulus(input logic [63:0] data, input logic valid);
    i_rx_tdata  = data;
    i_rx_tvalid = valid;
    @(posedge axis_clk);
    #1;
    if (o_tvalid === 1'b1) vcount++;
  endtask

  task automatic sendPayload(input int n, input logic [63:0] base);
    for (int k = 1; k <= n; k++) applyStimulus(base + 64'(k), 1'b1);
  endtask

  task automatic sendFrame(input logic [63:0] fap, input logic [63:0] base);
    applyStimulus(fap, 1'b1);
    sendPayload(15, base);
  endtask

  initial begin
    $display("[TB] start");
    axis_rst    = 1'b1;
    i_enable    = 1'b1;
    i_rx_tdata  = '0;
    i_rx_tvalid = 1'b0;

    // ---- reset: a FAP presented during reset must be ignored ----
    applyStimulus(fapWord(3'b111), 1'b1);
    applyStimulus(fapWord(3'b111), 1'b1);
    checkOutput("rst_rx_rdy",    64'(o_rx_rdy),        64'd0);
    checkOutput("rst_fap_miss",  64'(o_fap_missing),   64'd0);
    checkOutput("rst_tvalid",    64'(o_tvalid),        64'd0);
    checkOutput("rst_tdata",     o_tdata,              64'd0);
    checkOutput("rst_flags",     64'({o_remote_pd_ack, o_remote_pd_req, o_remote_rx_rdy}), 64'd0);
    axis_rst = 1'b0;

    // ---- lock: four good FAPs ----
    vcount = 0;
    applyStimulus(fapWord(3'b001), 1'b1);
    checkOutput("lock_fap1_rdy", 64'(o_rx_rdy), 64'd0);
    sendPayload(15, 64'h1000);
    sendFrame(fapWord(3'b001), 64'h2000);
    applyStimulus(fapWord(3'b001), 1'b1);
    checkOutput("lock_fap3_rdy", 64'(o_rx_rdy), 64'd0);
    sendPayload(15, 64'h3000);
    checkOutput("verify_no_fwd", 64'(vcount), 64'd0);
    vcount = 0;
    applyStimulus(fapWord(3'b001), 1'b1);
    checkOutput("lock_fap4_rdy",    64'(o_rx_rdy),        64'd1);
    checkOutput("lock_remote_rdy",  64'(o_remote_rx_rdy), 64'd1);
    checkOutput("lock_fap_not_fwd", 64'(o_tvalid),        64'd0);
    applyStimulus(64'h4001, 1'b1);
    checkOutput("lock_pay1_valid", 64'(o_tvalid), 64'd1);
    checkOutput("lock_pay1_data",  o_tdata,       64'h4001);
    sendPayload(14, 64'h4001);
    checkOutput("lock_pay_count", 64'(vcount), 64'd15);
    checkOutput("lock_pay_last",  o_tdata,     64'h400F);
    // A pattern match at pos 1 is payload, not a FAP.
    applyStimulus(fapWord(3'b001), 1'b1);
    sendPayload(0, 64'h0);
    applyStimulus(fapWord(3'b100), 1'b1);
    checkOutput("midframe_match_fwd", o_tdata, fapWord(3'b100));
    checkOutput("midframe_match_flags", 64'(o_remote_pd_ack), 64'd0);
    sendPayload(14, 64'h4101);

    // ---- single miss recovery ----
    vcount = 0;
    applyStimulus(BAD_FAP, 1'b1);
    checkOutput("miss1_rdy",        64'(o_rx_rdy),        64'd1);
    checkOutput("miss1_fap_miss",   64'(o_fap_missing),   64'd0);
    checkOutput("miss1_flags_hold", 64'(o_remote_rx_rdy), 64'd1);
    checkOutput("miss1_no_fwd",     64'(o_tvalid),        64'd0);
    sendPayload(15, 64'h5000);
    checkOutput("miss1_pay_count", 64'(vcount), 64'd15);
    applyStimulus(fapWord(3'b001), 1'b1);
    checkOutput("recover_rdy",      64'(o_rx_rdy),      64'd1);
    checkOutput("recover_fap_miss", 64'(o_fap_missing), 64'd0);
`ifdef QECIPHY_RX_MON_STATS_EN
    checkOutput("stats_miss1", 64'(o_miss_count), 64'd1);
`endif
    sendPayload(15, 64'h6000);
    // A second isolated miss must not accumulate with the first.
    applyStimulus(BAD_FAP, 1'b1);
    checkOutput("miss2_fap_miss", 64'(o_fap_missing), 64'd0);
    checkOutput("miss2_rdy",      64'(o_rx_rdy),      64'd1);
    sendPayload(15, 64'h6100);
    applyStimulus(fapWord(3'b001), 1'b1);
`ifdef QECIPHY_RX_MON_STATS_EN
    checkOutput("stats_miss2", 64'(o_miss_count), 64'd2);
`endif
    sendPayload(15, 64'h6200);

    // ---- power-down flags with valid gaps ----
    applyStimulus(fapWord(3'b010), 1'b1);
    checkOutput("pd_req_set",   64'(o_remote_pd_req), 64'd1);
    checkOutput("pd_ack_clear", 64'(o_remote_pd_ack), 64'd0);
    checkOutput("pd_rx_clear",  64'(o_remote_rx_rdy), 64'd0);
    sendPayload(5, 64'h7000);
    applyStimulus(64'hDEAD, 1'b0);
    checkOutput("gap_tvalid", 64'(o_tvalid), 64'd0);
    applyStimulus(64'hDEAD, 1'b0);
    applyStimulus(64'hDEAD, 1'b0);
    checkOutput("gap_tdata_hold", o_tdata, 64'h7005);
    sendPayload(10, 64'h7005);
    checkOutput("gap_last_valid", 64'(o_tvalid),        64'd1);
    checkOutput("gap_last_data",  o_tdata,              64'h700F);
    checkOutput("gap_ack_before", 64'(o_remote_pd_ack), 64'd0);
    applyStimulus(fapWord(3'b110), 1'b1);
    checkOutput("pd_ack_set",     64'(o_remote_pd_ack), 64'd1);
    checkOutput("pd_req_still",   64'(o_remote_pd_req), 64'd1);
    checkOutput("pd_fap_not_fwd", 64'(o_tvalid),        64'd0);
    sendPayload(15, 64'h8000);

    // ---- loss: two consecutive bad FAP slots ----
    applyStimulus(BAD_FAP, 1'b1);
    checkOutput("loss1_rdy",       64'(o_rx_rdy),        64'd1);
    checkOutput("loss1_pd_hold",   64'(o_remote_pd_req), 64'd1);
    sendPayload(15, 64'h9000);
    applyStimulus(BAD_FAP, 1'b1);
    checkOutput("loss2_rdy",      64'(o_rx_rdy),        64'd0);
    checkOutput("loss2_fap_miss", 64'(o_fap_missing),   64'd1);
    checkOutput("loss2_pd_req",   64'(o_remote_pd_req), 64'd0);
    checkOutput("loss2_pd_ack",   64'(o_remote_pd_ack), 64'd0);
    checkOutput("loss2_tvalid",   64'(o_tvalid),        64'd0);
    vcount = 0;
    for (int f = 0; f < 7; f++) sendFrame(fapWord(3'b001), 64'hA000);
    checkOutput("lost_sticky",    64'(o_fap_missing),   64'd1);
    checkOutput("lost_rdy",       64'(o_rx_rdy),        64'd0);
    checkOutput("lost_no_fwd",    64'(vcount),          64'd0);
    checkOutput("lost_flags",     64'(o_remote_rx_rdy), 64'd0);
    checkOutput("lost_tdata_hold", o_tdata,             64'h900F);
`ifdef QECIPHY_RX_MON_STATS_EN
    checkOutput("stats_lost", 64'(o_miss_count), 64'd4);
`endif

    // ---- disable clears LOST; then a verify failure ----
    i_enable = 1'b0;
    applyStimulus(fapWord(3'b001), 1'b1);
    checkOutput("dis_fap_miss", 64'(o_fap_missing), 64'd0);
    checkOutput("dis_rdy",      64'(o_rx_rdy),      64'd0);
    checkOutput("dis_tdata",    o_tdata,            64'd0);
`ifdef QECIPHY_RX_MON_STATS_EN
    checkOutput("stats_dis", 64'(o_miss_count), 64'd0);
`endif
    i_enable = 1'b1;
    sendFrame(fapWord(3'b001), 64'hB000);
    sendFrame(fapWord(3'b001), 64'hB100);
    applyStimulus(BAD_FAP, 1'b1);
    checkOutput("vfail_rdy", 64'(o_rx_rdy), 64'd0);
    sendPayload(15, 64'hB200);
    sendFrame(fapWord(3'b001), 64'hB300);
    sendFrame(fapWord(3'b001), 64'hB400);
    applyStimulus(fapWord(3'b001), 1'b1);
    checkOutput("vfail_fap3_rdy", 64'(o_rx_rdy), 64'd0);
    sendPayload(15, 64'hB500);
    applyStimulus(fapWord(3'b001), 1'b1);
    checkOutput("vfail_relock", 64'(o_rx_rdy), 64'd1);
    sendPayload(15, 64'hB600);

    // ---- disable mid-frame at pos 7 ----
    applyStimulus(fapWord(3'b111), 1'b1);
    sendPayload(6, 64'hC000);
    i_enable = 1'b0;
    applyStimulus(64'hC007, 1'b1);
    checkOutput("mid_dis_rdy",    64'(o_rx_rdy), 64'd0);
    checkOutput("mid_dis_tvalid", 64'(o_tvalid), 64'd0);
    checkOutput("mid_dis_tdata",  o_tdata,       64'd0);
    checkOutput("mid_dis_flags",  64'({o_remote_pd_ack, o_remote_pd_req, o_remote_rx_rdy}), 64'd0);
    i_enable = 1'b1;
    applyStimulus(fapWord(3'b001), 1'b1);
    checkOutput("mid_dis_relock1", 64'(o_rx_rdy), 64'd0);
    sendPayload(15, 64'hC100);
    sendFrame(fapWord(3'b001), 64'hC200);
    sendFrame(fapWord(3'b001), 64'hC300);
    applyStimulus(fapWord(3'b001), 1'b1);
    checkOutput("mid_dis_relock4", 64'(o_rx_rdy), 64'd1);
    applyStimulus(64'hC401, 1'b1);
    checkOutput("mid_dis_pay", o_tdata, 64'hC401);

    // ---- reset pulse mid-frame at pos 7 ----
    sendPayload(5, 64'hC401);
    axis_rst = 1'b1;
    applyStimulus(64'hD007, 1'b1);
    checkOutput("mid_rst_rdy",    64'(o_rx_rdy), 64'd0);
    checkOutput("mid_rst_tvalid", 64'(o_tvalid), 64'd0);
    checkOutput("mid_rst_tdata",  o_tdata,       64'd0);
    checkOutput("mid_rst_flags",  64'(o_remote_rx_rdy), 64'd0);
    axis_rst = 1'b0;
    applyStimulus(fapWord(3'b001), 1'b1);
    checkOutput("mid_rst_relock1", 64'(o_rx_rdy), 64'd0);
    sendPayload(15, 64'hD100);
    sendFrame(fapWord(3'b001), 64'hD200);
    sendFrame(fapWord(3'b001), 64'hD300);
    applyStimulus(fapWord(3'b011), 1'b1);
    checkOutput("mid_rst_relock4", 64'(o_rx_rdy), 64'd1);
    checkOutput("mid_rst_flags4",  64'({o_remote_pd_ack, o_remote_pd_req, o_remote_rx_rdy}), 64'd3);
    applyStimulus(64'hD401, 1'b1);
    checkOutput("mid_rst_pay_valid", 64'(o_tvalid), 64'd1);
    checkOutput("mid_rst_pay",       o_tdata,       64'hD401);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
